// File: rtl/f2i_seq.sv
// Multi-cycle float (s|e8|m7, bias EXP_BIAS) to 16-bit signed integer converter.
// Truncates toward zero, saturates out-of-range values, one shift per cycle.
module f2i_seq #(
  parameter int EXP_BIAS = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_sat,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, FIX, DONE} state_t;

  state_t      state_reg, state_next;
  logic        sign_reg, sign_next;
  logic        dir_reg, dir_next;      // 1 = shift left, 0 = shift right
  logic [2:0]  cnt_reg, cnt_next;
  logic [15:0] mag_reg, mag_next;
  logic        sat_reg, sat_next;
  logic [15:0] data_reg, data_next;
  logic        osat_reg, osat_next;

  // Operand decode, only consumed when an operand is accepted in IDLE
  logic signed [8:0] e_val;
  logic [15:0]       ld_mag;
  logic              ld_sat;
  logic              ld_dir;
  logic [2:0]        ld_cnt;

  assign e_val = $signed({1'b0, in_data[14:7]}) - $signed(9'(EXP_BIAS));

  always_comb begin
    ld_mag = {8'b0, 1'b1, in_data[6:0]};
    ld_sat = 1'b0;
    ld_dir = 1'b0;
    ld_cnt = 3'd0;
    if (e_val < 9'sd0) begin
      ld_mag = 16'h0000;
    end else if (e_val >= 9'sd15) begin
      if (!in_data[15]) begin
        ld_mag = 16'h7FFF;
        ld_sat = 1'b1;
      end else begin
        // -32768 is representable exactly; anything more negative clips to it
        ld_mag = 16'h8000;
        ld_sat = (e_val != 9'sd15) || (in_data[6:0] != 7'd0);
      end
    end else if (e_val < 9'sd7) begin
      ld_dir = 1'b0;
      ld_cnt = 3'(4'd7 - e_val[3:0]);
    end else begin
      ld_dir = 1'b1;
      ld_cnt = 3'(e_val[3:0] - 4'd7);
    end
  end

  always_comb begin
    state_next = state_reg;
    sign_next  = sign_reg;
    dir_next   = dir_reg;
    cnt_next   = cnt_reg;
    mag_next   = mag_reg;
    sat_next   = sat_reg;
    data_next  = data_reg;
    osat_next  = osat_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          sign_next  = in_data[15];
          dir_next   = ld_dir;
          cnt_next   = ld_cnt;
          mag_next   = ld_mag;
          sat_next   = ld_sat;
          state_next = (ld_cnt != 3'd0) ? SHIFT : FIX;
        end
      end
      SHIFT: begin
        mag_next = dir_reg ? {mag_reg[14:0], 1'b0} : {1'b0, mag_reg[15:1]};
        cnt_next = cnt_reg - 3'd1;
        if (cnt_reg == 3'd1) state_next = FIX;
      end
      FIX: begin
        // Negating 0x8000 wraps back to 0x8000, so the special needs no bypass
        data_next  = sign_reg ? (16'd0 - mag_reg) : mag_reg;
        osat_next  = sat_reg;
        state_next = DONE;
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      sign_reg  <= 1'b0;
      dir_reg   <= 1'b0;
      cnt_reg   <= 3'd0;
      mag_reg   <= 16'h0000;
      sat_reg   <= 1'b0;
      data_reg  <= 16'h0000;
      osat_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      sign_reg  <= sign_next;
      dir_reg   <= dir_next;
      cnt_reg   <= cnt_next;
      mag_reg   <= mag_next;
      sat_reg   <= sat_next;
      data_reg  <= data_next;
      osat_reg  <= osat_next;
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = data_reg;
  assign out_sat   = osat_reg;

endmodule

// File: tb/tb_f2i_seq.sv
// Self-checking bench for f2i_seq: value-level reference model, per-cycle
// handshake/latency monitor and directed vectors with literal expectations.
module tb_f2i_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_sat;
  logic        busy;

  f2i_seq #(.EXP_BIAS(127)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  logic [15:0] last_data;
  logic        last_sat;
  int          last_lat;

  typedef struct {
    logic [15:0] d;
    logic        s;
    int          lat;
    int          acc;
    bit          seen;
  } exp_t;
  exp_t q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: real value = (128+mant) * 2^(exp-127) / 128, truncated, clamped
  function automatic void model(input logic [15:0] f, output logic [15:0] d,
                                output logic s, output int lat);
    int e;
    longint v;
    e = int'(f[14:7]) - 127;
    s = 1'b0;
    if (e < 0) begin
      d = 16'h0000;
      lat = 2;
    end else if (e >= 15) begin
      lat = 2;
      if (!f[15]) begin
        d = 16'h7FFF; s = 1'b1;
      end else begin
        d = 16'h8000; s = !(e == 15 && f[6:0] == 7'd0);
      end
    end else begin
      v = (longint'(128 + int'(f[6:0])) << e) >> 7;
      if (f[15]) v = -v;
      if (v > 32767) begin v = 32767; s = 1'b1; end
      if (v < -32768) begin v = -32768; s = 1'b1; end
      d = v[15:0];
      lat = 2 + ((e < 7) ? (7 - e) : (e - 7));
    end
  endfunction

  // Single compare process: state/handshake/data against the model every cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() == 0) begin
        chk("idle_in_ready", in_ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_out_valid", out_valid, 0);
      end else begin
        int age;
        age = cyc - q[0].acc + 1;
        chk("busy_in_ready", in_ready, 0);
        chk("busy_flag", busy, 1);
        chk("out_valid_timing", out_valid, (age >= q[0].lat) ? 1 : 0);
        if (out_valid) begin
          chk("out_data", out_data, q[0].d);
          chk("out_sat", out_sat, q[0].s);
          if (!q[0].seen) begin
            q[0].seen = 1'b1;
            last_lat  = age;
            last_data = out_data;
            last_sat  = out_sat;
          end
          if (out_ready) begin
            void'(q.pop_front());
            done_cnt++;
          end
        end else if (age > 40) begin
          chk("monitor_timeout", 0, 1);
          void'(q.pop_front());
          done_cnt++;
        end
      end
      if (in_valid && in_ready) begin
        exp_t x;
        model(in_data, x.d, x.s, x.lat);
        x.acc  = cyc + 1;
        x.seen = 1'b0;
        q.push_back(x);
        acc_cnt++;
      end
    end
  end

  task automatic send(input logic [15:0] f, input bit garbage);
    int start = acc_cnt;
    int g = 0;
    in_data  = f;
    in_valid = 1'b1;
    do begin
      @(posedge clk); #1; g++;
    end while (acc_cnt == start && g < 20);
    in_valid = 1'b0;
    if (acc_cnt == start) chk("accept_timeout", 0, 1);
    if (garbage) begin
      for (int i = 0; i < 4; i++) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = 16'($urandom);
        @(posedge clk); #1;
      end
      in_valid = 1'b0;
    end
  endtask

  task automatic run_vec(input logic [15:0] f, input logic [15:0] ed, input logic es,
                         input int el, input int hold, input bit garbage);
    logic [15:0] md;
    logic        ms;
    int          ml;
    int          start_done;
    int          g;
    model(f, md, ms, ml);
    chk("model_pin", {md, 15'd0, ms}, {ed, 15'd0, es});
    chk("model_lat_pin", ml, el);
    start_done = done_cnt;
    out_ready  = (hold == 0);
    send(f, garbage);
    if (hold > 0) begin
      g = 0;
      while (!out_valid && g < 30) begin @(posedge clk); #1; g++; end
      repeat (hold) begin @(posedge clk); #1; end
      out_ready = 1'b1;
    end
    g = 0;
    while (done_cnt == start_done && g < 50) begin @(posedge clk); #1; g++; end
    if (done_cnt == start_done) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("result_data", last_data, ed);
      chk("result_sat", last_sat, es);
      chk("result_latency", last_lat, el);
      $display("xfer in=%h out=%h sat=%0d lat=%0d", f, last_data, last_sat, last_lat);
    end
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 16'h0000);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    run_vec(16'h3FC0, 16'h0001, 1'b0, 9, 0, 1'b0);
    run_vec(16'hC2C8, 16'hFF9C, 1'b0, 3, 0, 1'b0);
    run_vec(16'h46FF, 16'h7F80, 1'b0, 9, 0, 1'b0);
    run_vec(16'h4700, 16'h7FFF, 1'b1, 2, 0, 1'b0);
    run_vec(16'hC700, 16'h8000, 1'b0, 2, 0, 1'b0);
    run_vec(16'hC701, 16'h8000, 1'b1, 2, 0, 1'b0);
    run_vec(16'h7F80, 16'h7FFF, 1'b1, 2, 0, 1'b0);
    run_vec(16'h3F00, 16'h0000, 1'b0, 2, 0, 1'b0);
    run_vec(16'h0000, 16'h0000, 1'b0, 2, 0, 1'b0);
    run_vec(16'h8000, 16'h0000, 1'b0, 2, 0, 1'b0);
    run_vec(16'h4300, 16'h0080, 1'b0, 2, 0, 1'b0);
    run_vec(16'hC120, 16'hFFF6, 1'b0, 6, 0, 1'b0);
    run_vec(16'h3FC0, 16'h0001, 1'b0, 9, 5, 1'b1);

    // Reset in the middle of a shift sequence
    out_ready = 1'b1;
    send(16'h3FC0, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_data", out_data, 16'h0000);
    chk("midrst_out_sat", out_sat, 0);
    q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    run_vec(16'h4120, 16'h000A, 1'b0, 6, 0, 1'b0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
